cdce62005_spi_responder: RTL and testbench
==========================================

Name: cdce62005_spi_responder

Overview:
- Synthesizable SPI responder modelling the CDCE62005 end of the clock-chip configuration link.
- Oversamples spi_clk, spi_le and spi_mosi on the system clock.
- Decodes 32-bit LSB-first frames into register writes, read commands and EEPROM-copy commands, and returns register contents on spi_miso in the frame after a read command.
- Used as a loopback/emulation target on the board FPGA and as the bench model for the configuration master.

Parameters:
- NUM_REGS, 9, implemented registers, addresses 0..NUM_REGS-1 (max 15).
- SYNC_STAGES, 2, synchronizer depth on spi_clk/spi_le/spi_mosi (>=2).
- FRAME_BITS, 32, valid frame length in spi_clk rising edges.

Ports:
- clk  in  1  system clock; spi_clk must be <= clk/4.
- rst  in  1  asynchronous, active-high reset.
- spi_clk  in  1  serial clock; high only during frames.
- spi_le  in  1  latch enable; low = frame active.
- spi_mosi  in  1  serial data in, LSB first, sampled on spi_clk rise.
- spi_miso  out  1  serial data out, updated on spi_clk fall.
- wr_valid  out  1  one-cycle pulse, register written.
- wr_addr  out  4  written address.
- wr_data  out  28  written data, word[31:4].
- rd_cmd  out  1  one-cycle pulse, read command accepted.
- eeprom_copy  out  1  one-cycle pulse, copy command accepted.
- frame_err  out  1  one-cycle pulse, bad frame.
- frame_cnt  out  16  count of good frames, wraps at 0xFFFF->0.
- cfg_rd_addr  in  4  local register-file read address.
- cfg_rd_data  out  28  data at cfg_rd_addr, registered, 1-cycle latency.

Behaviour:
- Reset values: all outputs 0; register bank set to the package reset constants; readback disarmed; state IDLE.
- Synchronization: inputs pass through SYNC_STAGES flops; rise/fall detected on the synchronized copies.
- FSM IDLE -> SHIFT on spi_le fall.
  - In SHIFT, each spi_clk rise shifts spi_mosi into shreg[31] with a right shift, and bit_cnt increments, saturating at 63.
  - SHIFT -> DECODE on spi_le rise; DECODE -> IDLE after one cycle.
- Decode is performed only when bit_cnt == FRAME_BITS; otherwise frame_err pulses and no other action occurs.
  - word[3:0] < NUM_REGS: reg[addr] <= word[31:4]; wr_valid/wr_addr/wr_data asserted for one cycle.
  - word[3:0] == 4'hE: read command. rd_addr <= word[7:4] and readback armed; rd_cmd pulses.
  - word[3:0] == 4'hF: eeprom_copy pulses; register contents unchanged.
  - Any other address: frame_err pulses.
- frame_cnt increments on every decoded 32-bit frame, including read and copy commands.
- All DECODE pulses appear exactly one clk cycle after the synchronized spi_le rise.
- Readback frame: the first frame after an armed read is a readback frame.
  - MOSI content is ignored and not decoded.
  - tx word = {reg[rd_addr], rd_addr}; tx word = {28'h0, rd_addr} when rd_addr >= NUM_REGS.
  - tx bit0 is driven on spi_le fall; the next bit is driven on each spi_clk fall.
  - spi_miso = 0 outside readback frames.
  - Readback disarms at frame end whether or not the frame was complete; a short readback frame also raises frame_err.
- A second read command before the readback frame overwrites rd_addr.
- rst mid-frame: the frame is aborted with no pulses and the bank returns to reset constants.
- spi_le held low indefinitely: the FSM stays in SHIFT; bit_cnt saturates, so any later end raises frame_err.

Optional Feature:
- CDCE_LOCK_CMD_EN defined: a copy-command frame with word[5] = 1 (0x0000003F) also sets a lock flag. While locked, register writes are discarded and raise frame_err. The lock clears only on rst.
- Without the macro, word[5] is ignored and 0x3F behaves as 0x1F.

Decomposition:
- Package cdce62005_pkg holds:
  - REG_RST[0:8] reset constants, 28 bits each.
  - ADDR_RDCMD = 4'hE and ADDR_EEPROM = 4'hF.
  - The FSM state typedef (IDLE, SHIFT, DECODE).
- One natural sub-module, spi_in_sync: synchronizer plus edge detector for the three inputs, producing clk_rise, clk_fall, le_rise, le_fall and mosi_s.

Test Plan:
- Write frame 0xEB400320 -> wr_valid with wr_addr=0, wr_data=0xEB40032; cfg_rd_addr=0 returns 0xEB40032 next cycle; frame_cnt=1.
- Write 0x10000E65, then read command 0x0000005E, then a 32-clock readback frame -> rd_cmd pulse; master captures 0x10000E65 on spi_miso.
- Read command 0x000000CE (rd_addr 12) then readback -> spi_miso word 0x0000000C.
- 31-bit frame and 33-bit frame -> frame_err each; no wr_valid; registers unchanged; frame_cnt unchanged.
- Frame 0x0000001F -> eeprom_copy pulse only. With CDCE_LOCK_CMD_EN, 0x0000003F followed by write 0x68840303 -> frame_err, reg3 unchanged.
- Assert rst after 16 bits of a write to reg 1 -> no pulses; after release, a full frame to reg 1 writes normally; cfg_rd_addr=2 returns REG_RST[2].

Source files
------------

// File: rtl/cdce62005_pkg.sv
// Shared constants, types and reset values for the CDCE62005 SPI responder.
// Contents: register reset constants, command addresses, frame payload struct,
// FSM state type and a reset-value lookup helper.
package cdce62005_pkg;

  localparam int unsigned DATA_W  = 28;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned NUM_RST = 9;

  localparam logic [ADDR_W-1:0] ADDR_RDCMD  = 4'hE;
  localparam logic [ADDR_W-1:0] ADDR_EEPROM = 4'hF;

  localparam logic [DATA_W-1:0] REG_RST [0:NUM_RST-1] = '{
    28'h8140000, 28'h8140001, 28'h8140002, 28'h8140003, 28'h8140004,
    28'h1000E60, 28'h04BE19A, 28'hBD0037F, 28'h20009D9
  };

  // 32-bit frame as it appears after LSB-first shifting
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Reset value for a register index; unlisted registers reset to zero
  function automatic logic [DATA_W-1:0] reg_rst(input logic [ADDR_W-1:0] idx);
    if (32'(idx) < NUM_RST) return REG_RST[idx];
    return '0;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer and edge detector for the three SPI inputs.
// Ports: clk/rst system clock and async active-high reset; spi_clk, spi_le,
// spi_mosi raw pins; clk_rise/clk_fall/le_rise/le_fall registered one-cycle
// edge strobes; mosi_s synchronized data aligned with the strobes.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_le,
  input  logic spi_mosi,
  output logic clk_rise,
  output logic clk_fall,
  output logic le_rise,
  output logic le_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] le_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   clk_prev;
  logic                   le_prev;

  // spi_le idles high, so its chain resets high to avoid a false fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr   <= '0;
      le_sr    <= '1;
      mosi_sr  <= '0;
      clk_prev <= 1'b0;
      le_prev  <= 1'b1;
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      le_rise  <= 1'b0;
      le_fall  <= 1'b0;
      mosi_s   <= 1'b0;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
      le_sr    <= {le_sr[SYNC_STAGES-2:0], spi_le};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      clk_prev <= clk_sr[SYNC_STAGES-1];
      le_prev  <= le_sr[SYNC_STAGES-1];
      clk_rise <= clk_sr[SYNC_STAGES-1] & ~clk_prev;
      clk_fall <= ~clk_sr[SYNC_STAGES-1] & clk_prev;
      le_rise  <= le_sr[SYNC_STAGES-1] & ~le_prev;
      le_fall  <= ~le_sr[SYNC_STAGES-1] & le_prev;
      mosi_s   <= mosi_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/cdce62005_spi_responder.sv
// SPI responder emulating the CDCE62005 configuration interface.
// Decodes 32-bit LSB-first frames into register writes, read commands and
// EEPROM-copy commands; returns {reg, addr} on spi_miso in the frame after
// a read command.
// Ports: clk, rst (async active-high); spi_clk/spi_le/spi_mosi/spi_miso SPI
// pins; wr_valid/wr_addr/wr_data write strobe; rd_cmd, eeprom_copy,
// frame_err one-cycle pulses; frame_cnt good-frame counter;
// cfg_rd_addr/cfg_rd_data local register readback (1-cycle latency).
// Option: CDCE_LOCK_CMD_EN enables the copy-with-lock command (word[5]).
module cdce62005_spi_responder
  import cdce62005_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_le,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_cmd,
  output logic              eeprom_copy,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_cnt,
  input  logic [ADDR_W-1:0] cfg_rd_addr,
  output logic [DATA_W-1:0] cfg_rd_data
);

  logic clk_rise, clk_fall, le_rise, le_fall, mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_le   (spi_le),
    .spi_mosi (spi_mosi),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .le_rise  (le_rise),
    .le_fall  (le_fall),
    .mosi_s   (mosi_s)
  );

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    tx_idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-1:0]   rd_addr;
  logic                armed;
  logic                rb_frame;
  logic [WORD_W-1:0]   tx_word_c;
  logic                decode_ok_c;
  logic                wr_lock_c;
  frame_t              frm;

  assign frm = shreg;

  // A complete, non-readback frame is ready for decode
  assign decode_ok_c = (state_q == SHIFT) && le_rise && !rb_frame &&
                       (bit_cnt == CNT_W'(FRAME_BITS));

`ifdef CDCE_LOCK_CMD_EN
  logic lock_q;

  // Sticky write lock, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (decode_ok_c && (frm.addr == ADDR_EEPROM) && frm.data[1]) begin
      lock_q <= 1'b1;
    end
  end

  assign wr_lock_c = lock_q;
`else
  assign wr_lock_c = 1'b0;
`endif

  // Readback word; unimplemented addresses return only the address
  always_comb begin
    tx_word_c = {DATA_W'(0), rd_addr};
    if (rd_addr < ADDR_W'(NUM_REGS)) tx_word_c = {regs[rd_addr], rd_addr};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (le_fall) state_d = SHIFT;
      SHIFT:   if (le_rise) state_d = DECODE;
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift, readback drive, decode and register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      tx_idx      <= '0;
      rd_addr     <= '0;
      armed       <= 1'b0;
      rb_frame    <= 1'b0;
      spi_miso    <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_cmd      <= 1'b0;
      eeprom_copy <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      cfg_rd_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_rst(ADDR_W'(i));
    end else begin
      wr_valid    <= 1'b0;
      rd_cmd      <= 1'b0;
      eeprom_copy <= 1'b0;
      frame_err   <= 1'b0;

      cfg_rd_data <= (cfg_rd_addr < ADDR_W'(NUM_REGS)) ? regs[cfg_rd_addr] : '0;

      case (state_q)
        IDLE: begin
          if (le_fall) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            rb_frame <= armed;
            tx_idx   <= CNT_W'(1);
            spi_miso <= armed ? tx_word_c[0] : 1'b0;
          end
        end

        SHIFT: begin
          if (clk_rise) begin
            shreg <= {mosi_s, shreg[WORD_W-1:1]};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (clk_fall && rb_frame) begin
            spi_miso <= (tx_idx < CNT_W'(WORD_W)) ? tx_word_c[tx_idx[4:0]] : 1'b0;
            if (tx_idx < CNT_W'(WORD_W)) tx_idx <= tx_idx + CNT_W'(1);
          end
          if (le_rise) begin
            spi_miso <= 1'b0;
            rb_frame <= 1'b0;
            if (rb_frame) begin
              // Readback frames disarm regardless of length and are not decoded
              armed <= 1'b0;
              if (bit_cnt != CNT_W'(FRAME_BITS)) frame_err <= 1'b1;
            end else if (!decode_ok_c) begin
              frame_err <= 1'b1;
            end else if (frm.addr < ADDR_W'(NUM_REGS)) begin
              if (wr_lock_c) begin
                frame_err <= 1'b1;
              end else begin
                regs[frm.addr] <= frm.data;
                wr_valid       <= 1'b1;
                wr_addr        <= frm.addr;
                wr_data        <= frm.data;
                frame_cnt      <= frame_cnt + FCNT_W'(1);
              end
            end else if (frm.addr == ADDR_RDCMD) begin
              rd_addr   <= frm.data[ADDR_W-1:0];
              armed     <= 1'b1;
              rd_cmd    <= 1'b1;
              frame_cnt <= frame_cnt + FCNT_W'(1);
            end else if (frm.addr == ADDR_EEPROM) begin
              eeprom_copy <= 1'b1;
              frame_cnt   <= frame_cnt + FCNT_W'(1);
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// Directed, table-driven bench for cdce62005_spi_responder.
module tb_cdce62005_spi_responder;

  localparam int HP = 8;  // spi_clk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_le = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        rd_cmd;
  logic        eeprom_copy;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [3:0]  cfg_rd_addr = 4'h0;
  logic [27:0] cfg_rd_data;

  always #5 clk = ~clk;

  cdce62005_spi_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_le      (spi_le),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_cmd      (rd_cmd),
    .eeprom_copy (eeprom_copy),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data)
  );

  int errors = 0;
  int checks = 0;

  // Pulse counters observed away from the active edge
  int          n_wr = 0, n_rd = 0, n_cp = 0, n_er = 0;
  logic [3:0]  last_addr = 4'h0;
  logic [27:0] last_data = 28'h0;

  always @(negedge clk) begin
    if (wr_valid) begin
      n_wr++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (rd_cmd)      n_rd++;
    if (eeprom_copy) n_cp++;
    if (frame_err)   n_er++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [27:0] exp);
    cfg_rd_addr = a;
    repeat (2) @(negedge clk);
    check(name, 32'(cfg_rd_data), 32'(exp));
  endtask

  // Master frame: drives nbits of w (zeros past bit 31), captures spi_miso on each rise
  task automatic spi_frame(input logic [31:0] w, input int nbits, output logic [31:0] miso_w);
    logic [31:0] wv;
    wv = w;
    miso_w = 32'h0;
    spi_le = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? wv[i] : 1'b0;
      repeat (HP) @(negedge clk);
      if (i < 32) miso_w[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HP) @(negedge clk);
    spi_le = 1'b1;
    spi_mosi = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          wr;
    int          rd;
    int          cp;
    int          er;
    logic [3:0]  raddr;
    logic [27:0] rdata;
    int          cnt;      // -1: not checked
    bit          chk_miso;
    logic [31:0] miso;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    logic [31:0] mw;
    int b_wr, b_rd, b_cp, b_er;
    string tag;

    //             word          bits wr rd cp er  raddr  rdata         cnt  chkm  miso
    vecs[0]  = '{32'hEB400320, 32, 1, 0, 0, 0, 4'h0, 28'hEB40032,  1, 1'b1, 32'h0};
    vecs[1]  = '{32'h12345671, 31, 0, 0, 0, 1, 4'h1, 28'h8140001,  1, 1'b0, 32'h0};
    vecs[2]  = '{32'h12345671, 33, 0, 0, 0, 1, 4'h1, 28'h8140001,  1, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000001F, 32, 0, 0, 1, 0, 4'h0, 28'hEB40032,  2, 1'b0, 32'h0};
    vecs[4]  = '{32'h10000E65, 32, 1, 0, 0, 0, 4'h5, 28'h10000E6,  3, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000005E, 32, 0, 1, 0, 0, 4'h5, 28'h10000E6,  4, 1'b0, 32'h0};
    vecs[6]  = '{32'hFFFFFFFF, 32, 0, 0, 0, 0, 4'h0, 28'hEB40032, -1, 1'b1, 32'h10000E65};
    vecs[7]  = '{32'h000000CE, 32, 0, 1, 0, 0, 4'h5, 28'h10000E6, -1, 1'b0, 32'h0};
    vecs[8]  = '{32'h00000000, 32, 0, 0, 0, 0, 4'h0, 28'hEB40032, -1, 1'b1, 32'h0000000C};
    vecs[9]  = '{32'h0000003E, 32, 0, 1, 0, 0, 4'h3, 28'h8140003, -1, 1'b0, 32'h0};
    vecs[10] = '{32'h00000000, 16, 0, 0, 0, 1, 4'h0, 28'hEB40032, -1, 1'b1, 32'h00000033};
    vecs[11] = '{32'h00000004, 32, 1, 0, 0, 0, 4'h4, 28'h0000000, -1, 1'b1, 32'h0};
    vecs[12] = '{32'h1234567A, 32, 0, 0, 0, 1, 4'h0, 28'hEB40032, -1, 1'b0, 32'h0};
    vecs[13] = '{32'hABCDEF01, 70, 0, 0, 0, 1, 4'h1, 28'h8140001, -1, 1'b0, 32'h0};
    vecs[14] = '{32'h0000003F, 32, 0, 0, 1, 0, 4'h3, 28'h8140003, -1, 1'b0, 32'h0};
`ifdef CDCE_LOCK_CMD_EN
    vecs[15] = '{32'h68840303, 32, 0, 0, 0, 1, 4'h3, 28'h8140003, -1, 1'b0, 32'h0};
`else
    vecs[15] = '{32'h68840303, 32, 1, 0, 0, 0, 4'h3, 28'h6884030, -1, 1'b0, 32'h0};
`endif

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_pulses", 32'({wr_valid, rd_cmd, eeprom_copy, frame_err, spi_miso}), 32'h0);
    check("reset_wr_bus", 32'({wr_addr, wr_data}), 32'h0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    check("reset_cfg_rd_data", 32'(cfg_rd_data), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reg("reset_reg2", 4'h2, 28'h8140002);
    check_reg("reset_reg8", 4'h8, 28'h20009D9);

    for (int i = 0; i < NV; i++) begin
      b_wr = n_wr; b_rd = n_rd; b_cp = n_cp; b_er = n_er;
      spi_frame(vecs[i].word, vecs[i].nbits, mw);
      tag = $sformatf("v%0d", i);
      check({tag, "_wr_valid"}, 32'(n_wr - b_wr), 32'(vecs[i].wr));
      check({tag, "_rd_cmd"}, 32'(n_rd - b_rd), 32'(vecs[i].rd));
      check({tag, "_eeprom_copy"}, 32'(n_cp - b_cp), 32'(vecs[i].cp));
      check({tag, "_frame_err"}, 32'(n_er - b_er), 32'(vecs[i].er));
      if (vecs[i].wr > 0) begin
        check({tag, "_wr_addr"}, 32'(last_addr), 32'(vecs[i].word[3:0]));
        check({tag, "_wr_data"}, 32'(last_data), 32'(vecs[i].word[31:4]));
      end
      check_reg({tag, "_cfg_rd"}, vecs[i].raddr, vecs[i].rdata);
      if (vecs[i].cnt >= 0) check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(vecs[i].cnt));
      if (vecs[i].chk_miso) check({tag, "_miso"}, mw, vecs[i].miso);
    end

    // Reset after 16 bits of a write to reg 1: no pulses, bank back to reset values
    b_wr = n_wr; b_rd = n_rd; b_cp = n_cp; b_er = n_er;
    spi_le = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      spi_mosi = (i == 0 || i == 4) ? 1'b1 : 1'b0;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    spi_le = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check("midrst_pulses", 32'((n_wr - b_wr) + (n_rd - b_rd) + (n_cp - b_cp) + (n_er - b_er)), 32'h0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'h0);
    check_reg("midrst_reg0", 4'h0, 28'h8140000);
    check_reg("midrst_reg5", 4'h5, 28'h1000E60);

    b_wr = n_wr;
    spi_frame(32'h11111111, 32, mw);
    check("postrst_wr_valid", 32'(n_wr - b_wr), 32'h1);
    check_reg("postrst_reg1", 4'h1, 28'h1111111);
    check_reg("postrst_reg2", 4'h2, 28'h8140002);
    check("postrst_frame_cnt", 32'(frame_cnt), 32'h1);
    check("postrst_miso", mw, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
